// File: rtl/lm70_responder.sv
// SPI responder that emulates an LM70 temperature sensor in the clk domain.
// Optional shutdown/ID-word emulation: define LM70_RESP_SHUTDOWN_EN.
module lm70_responder #(
    parameter int unsigned           DATA_W     = 11,
    parameter int unsigned           FRAME_BITS = 16,
    parameter logic [FRAME_BITS-1:0] ID_WORD    = FRAME_BITS'(16'h800F)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n_in,
    input  logic              sck_in,
    input  logic              sio_in,
    output logic              sio_out,
    output logic              sio_oe,
    input  logic [DATA_W-1:0] temp_in,
    input  logic              temp_load,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              shutdown
);
    localparam int unsigned      CNT_W    = $clog2(FRAME_BITS) + 1;
    localparam int unsigned      TAIL_W   = FRAME_BITS - DATA_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cs_sync;
    logic [2:0]            r_sck_sync;
    logic [2:0]            r_sio_sync;
    logic [DATA_W-1:0]     r_temp_shadow;
    logic [FRAME_BITS-1:0] r_shift_reg;
    logic [FRAME_BITS-1:0] w_shift_nxt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_done_nxt;
    logic                  w_abort_nxt;
    logic                  r_sio_out;
    logic                  r_sio_oe;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_frame_abort;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic                  w_sck_rise;
    logic                  w_sck_fall;
    logic [DATA_W-1:0]     w_temp_sel;
    logic [FRAME_BITS-1:0] w_frame_word;
    logic                  w_unused_sio;

    // Bit 0 = metastability flop, bit 1 = synced value, bit 2 = previous for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync  <= 3'b111;
            r_sck_sync <= 3'b000;
            r_sio_sync <= 3'b000;
        end else begin
            r_cs_sync  <= {r_cs_sync[1:0], cs_n_in};
            r_sck_sync <= {r_sck_sync[1:0], sck_in};
            r_sio_sync <= {r_sio_sync[1:0], sio_in};
        end
    end

    assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_temp_shadow <= '0;
        end else if (temp_load) begin
            r_temp_shadow <= temp_in;
        end
    end

    // A load coinciding with the CS fall is forwarded straight into the frame.
    assign w_temp_sel = temp_load ? temp_in : r_temp_shadow;

`ifdef LM70_RESP_SHUTDOWN_EN
    logic [FRAME_BITS-1:0] r_wr_reg;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic                  r_shutdown;

    // Write word is clocked in after the read word; applied only when complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_reg   <= '0;
            r_wr_cnt   <= '0;
            r_shutdown <= 1'b0;
        end else if (r_state != DONE) begin
            r_wr_cnt <= '0;
        end else if (w_cs_rise) begin
            if (r_wr_cnt == CNT_FULL) begin
                if (&r_wr_reg) begin
                    r_shutdown <= 1'b1;
                end else if (r_wr_reg == '0) begin
                    r_shutdown <= 1'b0;
                end
            end
        end else if (w_sck_rise && (r_wr_cnt != CNT_FULL)) begin
            r_wr_reg <= {r_wr_reg[FRAME_BITS-2:0], r_sio_sync[1]};
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        end
    end

    assign w_frame_word = r_shutdown ? ID_WORD : {w_temp_sel, {TAIL_W{1'b1}}};
    assign shutdown     = r_shutdown;
    assign w_unused_sio = r_sio_sync[2];
`else
    assign w_frame_word = {w_temp_sel, {TAIL_W{1'b1}}};
    assign shutdown     = 1'b0;
    assign w_unused_sio = ^r_sio_sync;
`endif

    assign w_cnt_inc = (r_bit_cnt == CNT_FULL) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);

    // Next-state logic; a CS edge always takes priority over an SCK edge.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift_reg;
        w_cnt_nxt   = r_bit_cnt;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = w_frame_word;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_abort_nxt = 1'b1;
                end else if (w_sck_rise) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_FULL) begin
                        w_state_nxt = DONE;
                    end
                end else if (w_sck_fall) begin
                    w_shift_nxt = {r_shift_reg[FRAME_BITS-2:0], 1'b1};
                end
            end
            DONE: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state so SIO updates 3 clk after a pin edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_shift_reg   <= '0;
            r_bit_cnt     <= '0;
            r_sio_out     <= 1'b0;
            r_sio_oe      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift_reg   <= w_shift_nxt;
            r_bit_cnt     <= w_cnt_nxt;
            r_sio_out     <= (w_state_nxt == SHIFT) & w_shift_nxt[FRAME_BITS-1];
            r_sio_oe      <= (w_state_nxt == SHIFT);
            r_busy        <= (w_state_nxt != IDLE);
            r_frame_done  <= w_done_nxt;
            r_frame_abort <= w_abort_nxt;
        end
    end

    assign sio_out     = r_sio_out;
    assign sio_oe      = r_sio_oe;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign frame_abort = r_frame_abort;
endmodule

// File: tb/tb_lm70_responder.sv
// Randomized bench for lm70_responder: an SPI initiator model reads frames and
// compares them with the LM70 frame rules (temperature + ones tail, shutdown ID).
module tb_lm70_responder;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n_in;
    logic        sck_in;
    logic        sio_in;
    logic        temp_load;
    logic [10:0] temp_in;
    logic        sio_out;
    logic        sio_oe;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;
    logic        shutdown;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          n_abort = 0;
    logic [10:0] m_shadow;
    bit          m_shutdown;

    lm70_responder dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n_in    (cs_n_in),
        .sck_in     (sck_in),
        .sio_in     (sio_in),
        .sio_out    (sio_out),
        .sio_oe     (sio_oe),
        .temp_in    (temp_in),
        .temp_load  (temp_load),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_abort(frame_abort),
        .shutdown   (shutdown)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) n_done++;
        if (frame_abort === 1'b1) n_abort++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_frame();
        if (m_shutdown) return 16'h800F;
        return {m_shadow, 5'b11111};
    endfunction

    task automatic load_temp(input logic [10:0] v);
        @(negedge clk);
        temp_in   = v;
        temp_load = 1'b1;
        @(negedge clk);
        temp_load = 1'b0;
        m_shadow  = v;
    endtask

    task automatic sck_pulse();
        sck_in = 1'b1;
        repeat (HALF) @(negedge clk);
        sck_in = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // One CS-low transaction: nbits read clocks, then optional write word or extra clocks.
    task automatic xfer(input string tag, input int nbits, input int nextra, input bit wr_en,
                        input logic [15:0] wr_word, input bit byp, input logic [10:0] byp_val);
        logic [15:0] rd;
        logic [15:0] exp;
        int          d0;
        int          a0;
        int          npost;
        rd = '0;
        d0 = n_done;
        a0 = n_abort;
        cs_n_in = 1'b0;
        if (byp) begin
            repeat (2) @(negedge clk);
            temp_in   = byp_val;
            temp_load = 1'b1;
            @(negedge clk);
            temp_load = 1'b0;
            m_shadow  = byp_val;
            repeat (HALF - 3) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        exp = exp_frame();
        for (int i = 0; i < nbits; i++) begin
            check({tag, "_oe_in_frame"}, 32'(sio_oe), 32'd1);
            check({tag, "_busy_in_frame"}, 32'(busy), 32'd1);
            rd = {rd[14:0], sio_out};
            sck_pulse();
        end
        check({tag, "_data"}, 32'(rd), 32'(exp >> (16 - nbits)));
        if (nbits == 16) begin
            check({tag, "_oe_after_16"}, 32'(sio_oe), 32'd0);
            npost = wr_en ? 16 : nextra;
            for (int j = 0; j < npost; j++) begin
                sio_in = wr_en ? wr_word[15 - j] : 1'b0;
                sck_pulse();
                check({tag, "_oe_post"}, 32'(sio_oe), 32'd0);
                check({tag, "_busy_post"}, 32'(busy), 32'd1);
            end
            sio_in = 1'b0;
        end
        cs_n_in = 1'b1;
        repeat (6) @(negedge clk);
`ifdef LM70_RESP_SHUTDOWN_EN
        if (wr_en && nbits == 16) begin
            if (wr_word == 16'hFFFF) m_shutdown = 1'b1;
            else if (wr_word == 16'h0000) m_shutdown = 1'b0;
        end
`endif
        check({tag, "_done_pulses"}, 32'(n_done - d0), (nbits == 16) ? 32'd1 : 32'd0);
        check({tag, "_abort_pulses"}, 32'(n_abort - a0), (nbits == 16) ? 32'd0 : 32'd1);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_oe_idle"}, 32'(sio_oe), 32'd0);
        check({tag, "_shutdown"}, 32'(shutdown), 32'(m_shutdown));
    endtask

    initial begin
        int          nb;
        bit          byp;
        bit          wr;
        logic [15:0] wword;
        int          a0;

        rst        = 1'b1;
        cs_n_in    = 1'b1;
        sck_in     = 1'b0;
        sio_in     = 1'b0;
        temp_load  = 1'b0;
        temp_in    = '0;
        m_shadow   = '0;
        m_shutdown = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sio_out", 32'(sio_out), 32'd0);
        check("reset_sio_oe", 32'(sio_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_abort", 32'(frame_abort), 32'd0);
        check("reset_shutdown", 32'(shutdown), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        load_temp(11'h0C8);
        xfer("full_0c8", 16, 0, 1'b0, 16'h0, 1'b0, 11'h0);
        xfer("short8", 8, 0, 1'b0, 16'h0, 1'b0, 11'h0);
        xfer("full_again", 16, 0, 1'b0, 16'h0, 1'b0, 11'h0);
        xfer("bypass_7ff", 16, 0, 1'b0, 16'h0, 1'b1, 11'h7FF);
        xfer("shadow_kept", 16, 0, 1'b0, 16'h0, 1'b0, 11'h0);
        load_temp(11'h2A5);
        xfer("extra_sck", 16, 5, 1'b0, 16'h0, 1'b0, 11'h0);

`ifdef LM70_RESP_SHUTDOWN_EN
        xfer("wr_ffff", 16, 0, 1'b1, 16'hFFFF, 1'b0, 11'h0);
        xfer("id_word", 16, 0, 1'b0, 16'h0, 1'b0, 11'h0);
        xfer("wr_other", 16, 0, 1'b1, 16'h1234, 1'b0, 11'h0);
        xfer("wr_0000", 16, 0, 1'b1, 16'h0000, 1'b0, 11'h0);
        xfer("temp_back", 16, 0, 1'b0, 16'h0, 1'b0, 11'h0);
`endif

        // Reset in the middle of a frame.
        a0 = n_abort;
        cs_n_in = 1'b0;
        repeat (HALF) @(negedge clk);
        repeat (5) sck_pulse();
        rst = 1'b1;
        #1;
        check("midrst_oe", 32'(sio_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sio_out", 32'(sio_out), 32'd0);
        cs_n_in    = 1'b1;
        m_shadow   = '0;
        m_shutdown = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_abort", 32'(n_abort - a0), 32'd0);
        xfer("after_rst", 16, 0, 1'b0, 16'h0, 1'b0, 11'h0);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1) load_temp(11'($urandom));
            nb    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 16;
            byp   = ($urandom_range(0, 3) == 0);
            wr    = 1'b0;
            wword = 16'h0;
`ifdef LM70_RESP_SHUTDOWN_EN
            wr = (nb == 16) && ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 2))
                0:       wword = 16'hFFFF;
                1:       wword = 16'h0000;
                default: wword = 16'($urandom);
            endcase
`endif
            xfer("rand", nb, int'($urandom_range(0, 3)), wr, wword, byp, 11'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
